eth_rx_axi_reader: RTL and testbench
====================================

Name: eth_rx_axi_reader

Overview:
- AXI-Lite master engine that drains received Ethernet frames out of the AXI Ethernet peripheral without CPU involvement.
- On the peripheral's rx-ready interrupt it performs three reads:
  - the byte count register;
  - the protocol-type register;
  - one multi-beat read of the RX data register.
- Received words are forwarded on a valid/ready word stream with first/last markers and a per-frame status.
- Sits between the peripheral's AXI-Lite slave port and a packet buffer/DMA sink.

Parameters:
- ADDR_RX_DATA_COUNT, `ETHERNET_RX_DATA_COUNT, address of RX byte-count register
- ADDR_RX_PROTOCOL_TYPE, `ETHERNET_RX_PROTOCOL_TYPE, address of RX protocol-type register
- ADDR_RX_DATA, `ETHERNET_RX_DATA, address of RX data streaming register
- MAX_BYTES, 1518, largest accepted frame byte count
- TIMEOUT, 1024, cycles allowed waiting on any single AXI handshake

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  engine enable; sampled only in IDLE
- rx_ready_int  in  1  frame-available interrupt from peripheral (level)
- m_araddr  out  32  read address
- m_arvalid  out  1  read address valid
- m_arready  in  1  read address accepted
- m_rdata  in  32  read data
- m_rvalid  in  1  read data valid
- m_rlast  in  1  last read beat
- m_rready  out  1  master ready for read data
- out_data  out  32  frame word
- out_valid  out  1  word valid
- out_ready  in  1  sink ready
- out_first  out  1  first word of frame
- out_last  out  1  last word of frame
- frame_bytes  out  16  byte count of current frame (stable from first word to done)
- frame_proto  out  16  protocol type of current frame
- frame_done  out  1  one-cycle pulse, frame finished
- frame_err  out  2  status valid with frame_done: 0 ok, 1 length error, 2 beat mismatch, 3 timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; m_araddr 0.
- AR handshake rules:
  - m_arvalid is held with a stable address until m_arready is sampled high.
  - m_arvalid drops the cycle after acceptance.
- States and transitions:
  - IDLE: go to CNT_AR when enable && rx_ready_int.
  - CNT_AR: address = ADDR_RX_DATA_COUNT.
  - CNT_R: m_rready=1.
    - On m_rvalid, latch m_rdata[15:0] into frame_bytes.
    - If bytes==0 or bytes>MAX_BYTES, go to DONE with err=1 and issue no data read.
    - Otherwise go to PROTO_AR.
  - PROTO_AR: address = ADDR_RX_PROTOCOL_TYPE.
  - PROTO_R: latch m_rdata[15:0] into frame_proto, then go to DATA_AR.
  - DATA_AR: address = ADDR_RX_DATA. Compute expected beats = (bytes+3)>>2, using 17-bit intermediate arithmetic, with no wrap.
  - DATA_R:
    - m_rready = out_ready (pure combinational pass of backpressure, no skid buffer).
    - A beat transfers when m_rvalid && m_rready: out_data=m_rdata, out_valid=m_rvalid.
    - out_first is high on beat 0.
    - out_last is high on a beat with m_rlast or beat index == expected-1.
    - Beat counter is 11 bits, saturating.
    - On an m_rlast beat: if beats_received != expected, err=2; go to DONE.
    - If expected beats have been transferred without m_rlast, continue accepting and discarding further beats (out_valid=0) until m_rlast, then DONE with err=2.
  - DONE:
    - frame_done=1 for one cycle; frame_err driven.
    - Go to IDLE.
    - Hold in DONE while rx_ready_int is still high for at most 2 cycles before returning, to avoid re-triggering on a stale interrupt.
- Timeout:
  - A TIMEOUT-cycle counter is reset on every AR acceptance and every transferred R beat, and also while out_ready=0 in DATA_R (sink stall is not a fault).
  - Expiry in any *_AR/*_R state: drop m_arvalid/m_rready, go to DONE with err=3.
- Simultaneous events:
  - An m_rvalid beat arriving in an *_AR state is ignored (m_rready=0).
  - enable deasserted mid-frame does not abort; it takes effect in IDLE.
- Reset mid-operation: immediate return to IDLE; all outputs 0; no frame_done pulse.
- frame_bytes/frame_proto hold until the next CNT_R/PROTO_R capture.

Test Plan:
- Count=64, proto=0x0800, slave returns 16 beats with m_rlast on 16th, out_ready=1 -> 16 out words; out_first on word 0; out_last on word 15; frame_done with err=0, frame_bytes=64, frame_proto=0x0800.
- Count=61 (16 beats expected), out_ready toggled 1/0 every cycle -> m_rready mirrors out_ready; 16 words in order; no timeout; err=0.
- Count=0 and separately count=2000 -> exactly one AR issued (count reg), no data read, frame_done err=1.
- Count=64 but slave asserts m_rlast on beat 10 -> 10 words, out_last on 10th; err=2. Slave sends 18 beats -> 16 words out, 2 discarded; err=2.
- m_arready never asserted in DATA_AR -> after 1024 cycles m_arvalid drops; frame_done err=3; returns to IDLE.
- aresetn pulsed low during DATA_R beat 5 -> all outputs 0 asynchronously; no frame_done; next rx_ready_int starts fresh at CNT_AR.

Source files
------------

// File: rtl/eth_rx_axi_reader.sv
// AXI-Lite read engine that drains one received Ethernet frame per rx-ready interrupt
// (count, protocol, then a burst from the data register) onto a word stream.
`ifndef ETHERNET_RX_DATA_COUNT
`define ETHERNET_RX_DATA_COUNT 32'h0000_0010
`endif
`ifndef ETHERNET_RX_PROTOCOL_TYPE
`define ETHERNET_RX_PROTOCOL_TYPE 32'h0000_0014
`endif
`ifndef ETHERNET_RX_DATA
`define ETHERNET_RX_DATA 32'h0000_0018
`endif

// state    | meaning
// IDLE     | waiting for enable && rx_ready_int
// CNT_AR   | address phase, byte-count register
// CNT_R    | data phase, capture and range-check byte count
// PROTO_AR | address phase, protocol-type register
// PROTO_R  | data phase, capture protocol type
// DATA_AR  | address phase, data register burst
// DATA_R   | forward beats, then discard any overrun until m_rlast
// DONE     | frame_done pulse, brief hold on a stale interrupt
module eth_rx_axi_reader #(
  parameter logic [31:0] ADDR_RX_DATA_COUNT    = `ETHERNET_RX_DATA_COUNT,
  parameter logic [31:0] ADDR_RX_PROTOCOL_TYPE = `ETHERNET_RX_PROTOCOL_TYPE,
  parameter logic [31:0] ADDR_RX_DATA          = `ETHERNET_RX_DATA,
  parameter int          MAX_BYTES             = 1518,
  parameter int          TIMEOUT               = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        rx_ready_int,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic [15:0] frame_bytes,
  output logic [15:0] frame_proto,
  output logic        frame_done,
  output logic [1:0]  frame_err,
  output logic        busy
);

  localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [15:0]     MAX_B    = 16'(MAX_BYTES);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_BEAT = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_AR, S_CNT_R, S_PROTO_AR, S_PROTO_R, S_DATA_AR, S_DATA_R, S_DONE
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmr;
  logic          r_arvalid;
  logic [31:0]   r_araddr;
  logic [15:0]   r_bytes;
  logic [15:0]   r_proto;
  logic [16:0]   r_exp;
  logic [10:0]   r_beat;
  logic          r_disc;
  logic          r_done;
  logic [1:0]    r_err;
  logic [1:0]    r_hold;

  logic          w_tmr_zero;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_in_data;
  logic [16:0]   w_sum;
  logic [16:0]   w_exp;
  logic [10:0]   w_beat_nxt;
  logic          w_at_exp_last;
  logic          w_bad_len;
  logic          w_hit_exp;

  assign w_tmr_zero    = (r_tmr == '0);
  assign w_ar_hs       = r_arvalid && m_arready;
  assign w_r_hs        = m_rvalid && m_rready;
  assign w_in_data     = (r_state == S_DATA_R);
  // 17-bit sum so a 0xFFFF count cannot wrap the beat estimate
  assign w_sum         = {1'b0, r_bytes} + 17'd3;
  assign w_exp         = w_sum >> 2;
  assign w_beat_nxt    = (r_beat == 11'h7FF) ? r_beat : r_beat + 11'd1;
  assign w_at_exp_last = ({6'd0, r_beat} == (r_exp - 17'd1));
  assign w_hit_exp     = ({6'd0, w_beat_nxt} == r_exp);
  assign w_bad_len     = (m_rdata[15:0] == 16'd0) || (m_rdata[15:0] > MAX_B);

  // backpressure passes straight through; overrun beats are drained regardless of the sink
  assign m_rready   = (r_state == S_CNT_R) || (r_state == S_PROTO_R) ||
                      (w_in_data && (r_disc || out_ready));
  assign out_valid  = w_in_data && !r_disc && m_rvalid;
  assign out_data   = w_in_data ? m_rdata : 32'd0;
  assign out_first  = out_valid && (r_beat == 11'd0);
  assign out_last   = out_valid && (m_rlast || w_at_exp_last);
  assign busy       = (r_state != S_IDLE);

  assign m_arvalid   = r_arvalid;
  assign m_araddr    = r_araddr;
  assign frame_bytes = r_bytes;
  assign frame_proto = r_proto;
  assign frame_done  = r_done;
  assign frame_err   = r_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_arvalid <= 1'b0;
      r_araddr  <= 32'd0;
      r_bytes   <= 16'd0;
      r_proto   <= 16'd0;
      r_exp     <= 17'd0;
      r_beat    <= 11'd0;
      r_disc    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 2'd0;
      r_hold    <= 2'd0;
    end else begin
      r_done <= 1'b0;
      if (!w_tmr_zero) r_tmr <= r_tmr - TW'(1);
      case (r_state)
        S_IDLE: begin
          if (enable && rx_ready_int) begin
            r_state   <= S_CNT_AR;
            r_arvalid <= 1'b1;
            r_araddr  <= ADDR_RX_DATA_COUNT;
            r_tmr     <= TMR_LOAD;
          end
        end
        S_CNT_AR, S_PROTO_AR, S_DATA_AR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_tmr     <= TMR_LOAD;
            if (r_state == S_CNT_AR) begin
              r_state <= S_CNT_R;
            end else if (r_state == S_PROTO_AR) begin
              r_state <= S_PROTO_R;
            end else begin
              r_state <= S_DATA_R;
              r_exp   <= w_exp;
              r_beat  <= 11'd0;
              r_disc  <= 1'b0;
            end
          end else if (w_tmr_zero) begin
            r_arvalid <= 1'b0;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_err     <= ERR_TMO;
            r_hold    <= 2'd0;
          end
        end
        S_CNT_R: begin
          if (m_rvalid) begin
            r_bytes <= m_rdata[15:0];
            if (w_bad_len) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_LEN;
              r_hold  <= 2'd0;
            end else begin
              r_state   <= S_PROTO_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= ADDR_RX_PROTOCOL_TYPE;
              r_tmr     <= TMR_LOAD;
            end
          end else if (w_tmr_zero) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TMO;
            r_hold  <= 2'd0;
          end
        end
        S_PROTO_R: begin
          if (m_rvalid) begin
            r_proto   <= m_rdata[15:0];
            r_state   <= S_DATA_AR;
            r_arvalid <= 1'b1;
            r_araddr  <= ADDR_RX_DATA;
            r_tmr     <= TMR_LOAD;
          end else if (w_tmr_zero) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TMO;
            r_hold  <= 2'd0;
          end
        end
        S_DATA_R: begin
          if (w_r_hs) begin
            r_tmr <= TMR_LOAD;
            if (!r_disc) r_beat <= w_beat_nxt;
            if (m_rlast) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= (r_disc || !w_hit_exp) ? ERR_BEAT : ERR_OK;
              r_hold  <= 2'd0;
            end else if (!r_disc && w_hit_exp) begin
              r_disc <= 1'b1;
            end
          end else if (!out_ready) begin
            r_tmr <= TMR_LOAD;
          end else if (w_tmr_zero) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TMO;
            r_hold  <= 2'd0;
          end
        end
        S_DONE: begin
          // linger briefly so a not-yet-cleared interrupt does not restart the engine
          if (rx_ready_int && (r_hold != 2'd2)) begin
            r_hold <= r_hold + 2'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_axi_reader.sv
// Directed bench for eth_rx_axi_reader: scripted AXI-Lite slave, queue-based frame model,
// and a per-cycle monitor comparing the word stream and frame status.
module tb_eth_rx_axi_reader;

  localparam logic [31:0] A_CNT   = 32'h0000_0040;
  localparam logic [31:0] A_PROTO = 32'h0000_0044;
  localparam logic [31:0] A_DATA  = 32'h0000_0048;
  localparam int          TO      = 1024;
  localparam int          MAXB    = 1518;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic        rx_ready_int;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic [15:0] frame_bytes;
  logic [15:0] frame_proto;
  logic        frame_done;
  logic [1:0]  frame_err;
  logic        busy;

  eth_rx_axi_reader #(
    .ADDR_RX_DATA_COUNT   (A_CNT),
    .ADDR_RX_PROTOCOL_TYPE(A_PROTO),
    .ADDR_RX_DATA         (A_DATA),
    .MAX_BYTES            (MAXB),
    .TIMEOUT              (TO)
  ) u_dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .rx_ready_int(rx_ready_int),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rvalid    (m_rvalid),
    .m_rlast     (m_rlast),
    .m_rready    (m_rready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_first   (out_first),
    .out_last    (out_last),
    .frame_bytes (frame_bytes),
    .frame_proto (frame_proto),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] d;
    logic        f;
    logic        l;
  } word_t;

  // model state: expected words of the frame in flight and its completion status
  word_t       q[$];
  word_t       w_mon;
  logic [1:0]  e_err;
  logic [15:0] e_bytes;
  logic [15:0] e_proto;
  logic [15:0] m_proto = 16'd0;
  int          fid = 0;
  int          n_done = 0;
  int          n_ar = 0;
  int          n_words = 0;
  logic [1:0]  last_err = 2'd0;
  logic        tgl = 1'b0;

  function automatic logic [31:0] wdata(input int i);
    return {8'hC0, 8'(fid), 16'(i)};
  endfunction

  function automatic logic outs_nonzero();
    return |{m_araddr, m_arvalid, m_rready, out_data, out_valid, out_first, out_last,
             frame_bytes, frame_proto, frame_done, frame_err, busy};
  endfunction

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_arvalid && m_arready) n_ar++;
      if (out_valid && out_ready) begin
        n_words++;
        if (q.size() == 0) begin
          chk("extra_word", 32'(out_data), 32'hDEAD_DEAD);
        end else begin
          w_mon = q.pop_front();
          chk("out_data", out_data, w_mon.d);
          chk("out_first", 32'(out_first), 32'(w_mon.f));
          chk("out_last", 32'(out_last), 32'(w_mon.l));
          chk("frame_bytes_stable", 32'(frame_bytes), 32'(e_bytes));
        end
      end
      if (frame_done) begin
        n_done++;
        last_err = frame_err;
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("frame_bytes", 32'(frame_bytes), 32'(e_bytes));
        chk("frame_proto", 32'(frame_proto), 32'(e_proto));
        chk("words_left", 32'(q.size()), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic ar_accept(input logic [31:0] addr);
    int k = 0;
    while (!m_arvalid && k < 50) begin
      cyc();
      k++;
    end
    chk("ar_seen", 32'(m_arvalid), 32'd1);
    chk("araddr", m_araddr, addr);
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    chk("arvalid_drop", 32'(m_arvalid), 32'd0);
  endtask

  task automatic r_send(input logic [31:0] data, input logic last, input bit tog);
    bit hs = 0;
    int k  = 0;
    m_rvalid = 1'b1;
    m_rdata  = data;
    m_rlast  = last;
    while (!hs && k < 100) begin
      if (tog) begin
        out_ready = tgl;
        tgl = ~tgl;
      end
      @(negedge aclk);
      if (tog) chk("rready_mirror", 32'(m_rready), 32'(out_ready));
      hs = m_rready;
      @(posedge aclk);
      #1;
      k++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rdata  = 32'd0;
    if (!hs) chk("r_handshake", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (n_done == d0 && k < 200) begin
      cyc();
      k++;
    end
    chk("done_pulses", 32'(n_done - d0), 32'd1);
    k = 0;
    while (busy && k < 10) begin
      cyc();
      k++;
    end
    chk("back_to_idle", 32'(busy), 32'd0);
  endtask

  // nsend: beats the slave supplies (m_rlast on the final one); stall: never accept data AR;
  // rst_at: beat index at which reset is pulsed (-1 for none)
  task automatic frame(input logic [15:0] cnt, input logic [15:0] proto, input int nsend,
                       input bit tog, input bit stall, input int rst_at);
    int  exp_b;
    int  nw;
    int  d0;
    int  hi;
    int  k;
    bit  bad;
    bit  addr_ok;
    fid++;
    bad   = (cnt == 16'd0) || (int'(cnt) > MAXB);
    exp_b = (int'(cnt) + 3) / 4;
    q.delete();
    e_bytes = cnt;
    if (bad) e_err = 2'd1;
    else begin
      m_proto = proto;
      if (stall) e_err = 2'd3;
      else       e_err = (nsend == exp_b) ? 2'd0 : 2'd2;
    end
    e_proto = m_proto;
    if (!bad && !stall) begin
      nw = (nsend < exp_b) ? nsend : exp_b;
      for (int i = 0; i < nw; i++) q.push_back('{wdata(i), (i == 0), (i == nw - 1)});
    end
    d0 = n_done;
    rx_ready_int = 1'b1;
    ar_accept(A_CNT);
    rx_ready_int = 1'b0;
    r_send({16'hBEEF, cnt}, 1'b1, 1'b0);
    if (!bad) begin
      ar_accept(A_PROTO);
      r_send({16'h1234, proto}, 1'b1, 1'b0);
      if (stall) begin
        k = 0;
        while (!m_arvalid && k < 50) begin
          cyc();
          k++;
        end
        hi = 0;
        addr_ok = 1;
        while (m_arvalid && hi < 3000) begin
          if (m_araddr != A_DATA) addr_ok = 0;
          hi++;
          cyc();
        end
        chk("timeout_arvalid_cycles", 32'(hi), 32'(TO));
        chk("timeout_addr_stable", 32'(addr_ok), 32'd1);
      end else begin
        ar_accept(A_DATA);
        for (int i = 0; i < nsend; i++) begin
          if (i == rst_at) begin
            m_rvalid = 1'b1;
            m_rdata  = wdata(i);
            #2;
            aresetn = 1'b0;
            #1;
            chk("async_reset_outputs", 32'(outs_nonzero()), 32'd0);
            m_rvalid = 1'b0;
            m_rdata  = 32'd0;
            repeat (3) cyc();
            aresetn = 1'b1;
            cyc();
            chk("no_done_on_reset", 32'(n_done - d0), 32'd0);
            chk("idle_after_reset", 32'(busy), 32'd0);
            q.delete();
            m_proto = 16'd0;
            out_ready = 1'b1;
            return;
          end
          r_send(wdata(i), (i == nsend - 1), tog);
        end
      end
    end
    out_ready = 1'b1;
    wait_done(d0);
  endtask

  int a0;
  int w0;

  initial begin
    aresetn      = 1'b0;
    enable       = 1'b0;
    rx_ready_int = 1'b0;
    m_arready    = 1'b0;
    m_rdata      = 32'd0;
    m_rvalid     = 1'b0;
    m_rlast      = 1'b0;
    out_ready    = 1'b1;
    repeat (3) cyc();
    chk("reset_outputs", 32'(outs_nonzero()), 32'd0);
    chk("reset_araddr", m_araddr, 32'd0);
    aresetn = 1'b1;
    cyc();

    rx_ready_int = 1'b1;
    repeat (20) cyc();
    chk("disabled_no_ar", 32'(n_ar), 32'd0);
    chk("disabled_idle", 32'(busy), 32'd0);
    rx_ready_int = 1'b0;
    enable = 1'b1;
    cyc();

    a0 = n_ar; w0 = n_words;
    frame(16'd64, 16'h0800, 16, 1'b0, 1'b0, -1);
    chk("f64_words", 32'(n_words - w0), 32'd16);
    chk("f64_ars", 32'(n_ar - a0), 32'd3);
    chk("f64_err", 32'(last_err), 32'd0);

    w0 = n_words;
    frame(16'd61, 16'h86DD, 16, 1'b1, 1'b0, -1);
    chk("f61_words", 32'(n_words - w0), 32'd16);
    chk("f61_err", 32'(last_err), 32'd0);

    a0 = n_ar; w0 = n_words;
    frame(16'd0, 16'h0000, 0, 1'b0, 1'b0, -1);
    chk("f0_ars", 32'(n_ar - a0), 32'd1);
    chk("f0_words", 32'(n_words - w0), 32'd0);
    chk("f0_err", 32'(last_err), 32'd1);

    a0 = n_ar;
    frame(16'd2000, 16'h0000, 0, 1'b0, 1'b0, -1);
    chk("f2000_ars", 32'(n_ar - a0), 32'd1);
    chk("f2000_proto_held", 32'(frame_proto), 32'h86DD);

    w0 = n_words;
    frame(16'd64, 16'h0800, 10, 1'b0, 1'b0, -1);
    chk("short_words", 32'(n_words - w0), 32'd10);
    chk("short_err", 32'(last_err), 32'd2);

    w0 = n_words;
    frame(16'd64, 16'h0800, 18, 1'b0, 1'b0, -1);
    chk("long_words", 32'(n_words - w0), 32'd16);
    chk("long_err", 32'(last_err), 32'd2);

    w0 = n_words;
    frame(16'd1518, 16'h0800, 380, 1'b0, 1'b0, -1);
    chk("max_words", 32'(n_words - w0), 32'd380);
    chk("max_err", 32'(last_err), 32'd0);

    frame(16'd1519, 16'h0000, 0, 1'b0, 1'b0, -1);
    chk("over_err", 32'(last_err), 32'd1);

    frame(16'd8, 16'h0806, 0, 1'b0, 1'b1, -1);
    chk("tmo_err", 32'(last_err), 32'd3);
    chk("tmo_arvalid_low", 32'(m_arvalid), 32'd0);

    frame(16'd64, 16'h0800, 16, 1'b0, 1'b0, 5);

    w0 = n_words;
    frame(16'd5, 16'h0800, 2, 1'b0, 1'b0, -1);
    chk("fresh_words", 32'(n_words - w0), 32'd2);
    chk("fresh_err", 32'(last_err), 32'd0);
    chk("fresh_bytes", 32'(frame_bytes), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
